arbitro_rodada: RTL
===================

Name: arbitro_rodada

Overview:
- Round referee for the two-player reaction game; sits directly upstream of the score/LED stage.
- Waits a pseudo-random delay after a start press, then lights GO.
- Decides the round winner from the two player buttons: first press after GO wins; a press before GO is a false start and awards the opponent.
- Emits single-cycle p1vic/p2vic pulses consumed by the score stage.

Parameters:
- DELAY_MIN, 1000, minimum ARMED wait in clock cycles.
- DELAY_RANGE_BITS, 10, random extra wait = LFSR low bits, range 0..2^DELAY_RANGE_BITS-1 cycles.
- TIMEOUT_CYCLES, 50000, GO window length before the round is voided.
- COOLDOWN_CYCLES, 500, dead time after a round before start is accepted again.
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  raw start button, asynchronous.
- b1  in  1  raw player-1 button, asynchronous.
- b2  in  1  raw player-2 button, asynchronous.
- hold  in  1  high = match over; IDLE ignores start.
- go_led  out  1  high while in GO.
- p1vic  out  1  one-cycle pulse, point to player 1.
- p2vic  out  1  one-cycle pulse, point to player 2.
- falta  out  1  one-cycle pulse, coincident with a vic pulse caused by a false start.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Synchronous active-high reset:
  - state = IDLE; all outputs 0; counters 0; LFSR = LFSR_SEED.
  - Sync and edge flops = 0, so a button held through reset yields one edge after release. In IDLE that edge is ignored, except for start.
- Inputs: each button passes through a 2-flop synchronizer, then a rising-edge detector. Press latency is 3 cycles from the raw edge to the internal event. Levels are never used, only edges.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle in every state.
- FSM states: IDLE, ARMED, GO, RESULT, COOLDOWN.
- IDLE:
  - start edge && !hold -> ARMED.
  - Load wait counter = DELAY_MIN + lfsr[DELAY_RANGE_BITS-1:0]; counter width covers DELAY_MIN + 2^DELAY_RANGE_BITS - 1.
- ARMED: counter decrements once per cycle.
  - b1 edge only -> RESULT, winner P2, falta set.
  - b2 edge only -> RESULT, winner P1, falta set.
  - Both edges in the same cycle -> COOLDOWN, no pulse.
  - Counter == 0 with no edge -> GO; load timeout counter = TIMEOUT_CYCLES - 1.
  - A button edge in the same cycle the counter reaches 0 counts as a false start.
- GO: go_led = 1.
  - b1 edge only -> RESULT, winner P1.
  - b2 edge only -> RESULT, winner P2.
  - Both in the same cycle -> tie (see Optional Feature).
  - Timeout counter == 0 -> COOLDOWN, no pulse.
- RESULT: lasts exactly one cycle.
  - Registered p1vic or p2vic = 1; falta = 1 if false start.
  - go_led = 0; then -> COOLDOWN.
- COOLDOWN: load COOLDOWN_CYCLES - 1, count to 0, -> IDLE. All presses are ignored.
- Invariants:
  - p1vic and p2vic are never high together.
  - At most one pulse per round.
  - Outputs are registered, with no combinational path from inputs.
- hold rising mid-round: no effect; hold only gates the IDLE start.
- Reset mid-round: aborts immediately with no pulse; go_led drops the next edge.

Optional Feature:
- Macro ARBITRO_TIE_ALT_EN.
- Defined: a GO-state tie awards the point alternately via a toggle flop that starts at P1 after reset and flips on each tie; -> RESULT.
- Undefined: a GO-state tie -> COOLDOWN with no pulse.
- ARMED double false start is always void in both builds.

Decomposition:
- Package arbitro_pkg:
  - state_t enum (IDLE, ARMED, GO, RESULT, COOLDOWN).
  - winner_t enum (NONE, P1, P2).
  - LFSR_TAPS constant.
- Sub-module sync_borda: 2-flop synchronizer plus rising-edge detector, one bit, clock/reset/din/pulse.
- Instantiated three times: start, b1, b2.

Test Plan:
All scenarios use DELAY_MIN=4, DELAY_RANGE_BITS=2, TIMEOUT_CYCLES=20, COOLDOWN_CYCLES=3.
- Normal P1 win: start pulse, wait for go_led, b1 rises 2 cycles later -> p1vic high exactly 1 cycle, falta=0, then busy=0 after 3 cooldown cycles.
- False start: start pulse, b2 rises 1 cycle after ARMED entry -> p1vic=1 and falta=1 for one cycle; go_led never asserts.
- Timeout: start, no presses for 20 cycles after go_led -> go_led drops, no vic pulse, back to IDLE after cooldown.
- Simultaneous press in GO:
  - Macro undefined -> no pulse.
  - Macro defined -> first tie gives p1vic, second tie gives p2vic.
- hold=1 with start pulse -> busy stays 0; reset asserted while in GO -> next cycle go_led=0, busy=0, no pulse.
- Delay range: 200 rounds -> ARMED duration always within 4..7 cycles; check that every value 4..7 occurs.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared types and LFSR helpers for the two-player round referee.
package arbitro_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, GO, RESULT, COOLDOWN} state_t;
  typedef enum logic [1:0] {NONE, P1, P2} winner_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sync_borda.sv
// Two-flop synchronizer plus rising-edge detector for one raw button.
module sync_borda (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Event is visible to the consumer on the third clock edge after the raw press.
  assign pulse = s2 & ~s3;

endmodule

// File: rtl/arbitro_rodada.sv
// Round referee: random arming delay, GO window, winner/false-start pulses.
// Optional build macro ARBITRO_TIE_ALT_EN: GO-state ties award the point alternately.
module arbitro_rodada
  import arbitro_pkg::*;
#(
  parameter int unsigned DELAY_MIN        = 1000,
  parameter int unsigned DELAY_RANGE_BITS = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 50000,
  parameter int unsigned COOLDOWN_CYCLES  = 500,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic b1,
  input  logic b2,
  input  logic hold,
  output logic go_led,
  output logic p1vic,
  output logic p2vic,
  output logic falta,
  output logic busy
);

  localparam int unsigned DELAY_MAX = DELAY_MIN + (32'(1) << DELAY_RANGE_BITS) - 1;
  localparam int unsigned MAX_A     = (DELAY_MAX > TIMEOUT_CYCLES) ? DELAY_MAX : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (MAX_A > COOLDOWN_CYCLES) ? MAX_A : COOLDOWN_CYCLES;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);

  logic          ev_start, ev_b1, ev_b2;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
`ifdef ARBITRO_TIE_ALT_EN
  winner_t       tie_winner;
`endif

  sync_borda u_sync_start (.clock(clock), .reset(reset), .din(start), .pulse(ev_start));
  sync_borda u_sync_b1    (.clock(clock), .reset(reset), .din(b1),    .pulse(ev_b1));
  sync_borda u_sync_b2    (.clock(clock), .reset(reset), .din(b2),    .pulse(ev_b2));

  // ARMED lasts exactly the loaded count: it leaves in the cycle the counter reaches 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      go_led <= 1'b0;
      p1vic  <= 1'b0;
      p2vic  <= 1'b0;
      falta  <= 1'b0;
      busy   <= 1'b0;
`ifdef ARBITRO_TIE_ALT_EN
      tie_winner <= P1;
`endif
    end else begin
      lfsr  <= lfsr_next(lfsr);
      p1vic <= 1'b0;
      p2vic <= 1'b0;
      falta <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_start && !hold) begin
            state <= ARMED;
            busy  <= 1'b1;
            cnt   <= CW'(DELAY_MIN) + CW'(lfsr[DELAY_RANGE_BITS-1:0]);
          end
        end
        ARMED: begin
          cnt <= cnt - CW'(1);
          if (ev_b1 && ev_b2) begin
            state <= COOLDOWN;
            cnt   <= CW'(COOLDOWN_CYCLES - 1);
          end else if (ev_b1) begin
            state <= RESULT;
            p2vic <= 1'b1;
            falta <= 1'b1;
          end else if (ev_b2) begin
            state <= RESULT;
            p1vic <= 1'b1;
            falta <= 1'b1;
          end else if (cnt <= CW'(1)) begin
            state  <= GO;
            go_led <= 1'b1;
            cnt    <= CW'(TIMEOUT_CYCLES - 1);
          end
        end
        GO: begin
          if (ev_b1 && ev_b2) begin
            go_led <= 1'b0;
`ifdef ARBITRO_TIE_ALT_EN
            state <= RESULT;
            if (tie_winner == P2) p2vic <= 1'b1;
            else                  p1vic <= 1'b1;
            tie_winner <= (tie_winner == P2) ? P1 : P2;
`else
            state <= COOLDOWN;
            cnt   <= CW'(COOLDOWN_CYCLES - 1);
`endif
          end else if (ev_b1) begin
            state  <= RESULT;
            go_led <= 1'b0;
            p1vic  <= 1'b1;
          end else if (ev_b2) begin
            state  <= RESULT;
            go_led <= 1'b0;
            p2vic  <= 1'b1;
          end else if (cnt == '0) begin
            state  <= COOLDOWN;
            go_led <= 1'b0;
            cnt    <= CW'(COOLDOWN_CYCLES - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESULT: begin
          state <= COOLDOWN;
          cnt   <= CW'(COOLDOWN_CYCLES - 1);
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          go_led <= 1'b0;
        end
      endcase
    end
  end

endmodule
